mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory word-address width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 s_req  in  1  scalar (16-bit) access request; held until s_ack.
REQ-005 s_we  in  1  scalar write (1) / read (0).
REQ-006 s_addr  in  ADDR_W  scalar word address.
REQ-007 s_wdata  in  16  scalar write data.
REQ-008 s_rdata  out  16  scalar read data; valid while s_ack=1.
REQ-009 s_ack  out  1  one-cycle scalar completion pulse.
REQ-010 v_req  in  1  vector (128-bit) access request; held until v_ack.
REQ-011 v_we, v_addr, v_wdata  in  1/ADDR_W/128  vector write flag, base address, write data.
REQ-012 v_rdata  out  128  vector read data; valid while v_ack=1.
REQ-013 v_ack  out  1  one-cycle vector completion pulse.
REQ-014 mem_addr  out  ADDR_W  shared 16-bit memory address.
REQ-015 mem_we  out  1  shared memory write enable.
REQ-016 mem_wdata  out  16  shared memory write data.
REQ-017 mem_rdata  in  16  memory read data, valid the cycle after mem_addr presented.
REQ-018 stall  out  1  pipeline hold.

Function
REQ-019 States: IDLE, S_ACC, V_ACC, DRAIN, RESP. mem_addr/mem_we/mem_wdata are registered.
REQ-020 IDLE: sample requests and latch the granted port's we/addr/wdata. Scalar goes to S_ACC, vector goes to V_ACC, none stays IDLE.
REQ-021 Both requests in the same IDLE cycle: grant the port not granted last (round-robin). last_grant resets to vector, so scalar wins the first tie.
REQ-022 S_ACC, one cycle: mem_addr=latched addr, mem_we=latched we, mem_wdata=latched data. Then go to DRAIN.
REQ-023 V_ACC, 8 cycles, beat counter k=0..7: mem_addr=(base+k) mod 2^ADDR_W, mem_we=latched we, mem_wdata=v_wdata[16k+15:16k]. After k=7, go to DRAIN.
REQ-024 Vector read: mem_rdata from beat k is captured into v_rdata[16k+15:16k] one cycle after beat k. Beat 7 is captured in DRAIN.
REQ-025 Scalar read: mem_rdata is captured into s_rdata in DRAIN.
REQ-026 DRAIN, one cycle, mem_we=0. Then go to RESP.
REQ-027 RESP, one cycle: assert the ack of the granted port only. No new grant in RESP. Then go to IDLE.
REQ-028 Latency from request sampled in IDLE at cycle 0: scalar ack at cycle 3, vector ack at cycle 10, for reads and writes alike.
REQ-029 Latched fields are used for the whole transaction. Changes or req deassertion on the inputs mid-transaction are ignored; the transaction completes.
REQ-030 stall=(s_req & ~s_ack) | (v_req & ~v_ack), combinational.
REQ-031 In IDLE, DRAIN and RESP, mem_we=0. In IDLE, mem_addr and mem_wdata are 0.
REQ-032 s_rdata and v_rdata hold their values until the next read of the same port overwrites them. Writes leave them unchanged.
REQ-033 Address wrap: base 2^ADDR_W-3 accesses words 2^ADDR_W-3..2^ADDR_W-1, then 0..4.

Reset
REQ-034 On rst: state=IDLE, k=0, last_grant=vector, s_ack=v_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, s_rdata=0, v_rdata=0.
REQ-035 rst mid-transaction aborts it at that edge with no ack. Memory words already written by a partial vector write stay written.
REQ-036 rst has priority over every state transition.

Verification
REQ-037 Scalar write s_addr=0x0010, s_wdata=0xBEEF: mem_we=1, addr 0x0010 at cycle 1; s_ack at cycle 3; stall=1 cycles 0-2, 0 at cycle 3.
REQ-038 Vector read base 0x0100, memory word i=0x1000+i: addrs 0x0100..0x0107 in cycles 1-8; v_ack at cycle 10; v_rdata=0x1007_1006_..._1000.
REQ-039 s_req and v_req both asserted from reset: scalar served first (ack cycle 3); vector granted at IDLE cycle 4 (ack cycle 14); with both held continuously, grants alternate.
REQ-040 Vector write base 0xFFFE: writes to 0xFFFE, 0xFFFF, 0x0000..0x0005 with lanes 0..7 in order.
REQ-041 rst at beat k=3 of a vector write: IDLE next cycle; mem_we=0; no v_ack; only 3 words written; a following scalar read completes normally with ack at cycle 3.
REQ-042 s_addr changed and s_req dropped at cycle 1 of a scalar read: the original address is used, and s_ack still pulses at cycle 3.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 16-bit memory port between a scalar (16-bit)
// requester and a vector (8 x 16-bit) requester. Requests are granted in IDLE
// with round-robin tie-breaking. Each transaction runs to completion on its
// latched fields and ends with a one-cycle ack on the granted port.
module mem_port_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_req,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [15:0]       s_wdata,
  output logic [15:0]       s_rdata,
  output logic              s_ack,
  input  logic              v_req,
  input  logic              v_we,
  input  logic [ADDR_W-1:0] v_addr,
  input  logic [127:0]      v_wdata,
  output logic [127:0]      v_rdata,
  output logic              v_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              stall
);

  typedef enum logic [2:0] {IDLE, S_ACC, V_ACC, DRAIN, RESP} state_t;

  state_t            state_q, state_d;
  logic [2:0]        k_q, k_d;        // beat currently on the memory bus in V_ACC
  logic [2:0]        k_next;          // beat to present on the following cycle
  logic [2:0]        cap_lane;        // lane whose read data is on mem_rdata now
  logic              last_vec_q, last_vec_d;  // 1: vector port holds the grant
  logic              lat_we_q, lat_we_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [127:0]      lat_wdata_q, lat_wdata_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              mem_we_d;
  logic [15:0]       mem_wdata_d;
  logic              s_ack_d, v_ack_d;
  logic              grant_vec;

  // Vector wins if it asks alone, or on a tie when scalar was served last.
  assign grant_vec = v_req & (~s_req | ~last_vec_q);
  assign k_next    = k_q + 3'd1;
  assign cap_lane  = k_q - 3'd1;
  assign stall     = (s_req & ~s_ack) | (v_req & ~v_ack);

  // Next-state, grant and next memory-bus values (bus is registered below).
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    k_d         = k_q;
    last_vec_d  = last_vec_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    mem_addr_d  = '0;
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;
    s_ack_d     = 1'b0;
    v_ack_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_req | v_req) begin
          last_vec_d = grant_vec;
          k_d        = 3'd0;
          if (grant_vec) begin
            lat_we_d    = v_we;
            lat_addr_d  = v_addr;
            lat_wdata_d = v_wdata;
            mem_addr_d  = v_addr;
            mem_we_d    = v_we;
            mem_wdata_d = v_wdata[15:0];
            state_d     = V_ACC;
          end else begin
            lat_we_d    = s_we;
            lat_addr_d  = s_addr;
            lat_wdata_d = {112'd0, s_wdata};
            mem_addr_d  = s_addr;
            mem_we_d    = s_we;
            mem_wdata_d = s_wdata;
            state_d     = S_ACC;
          end
        end
      end
      S_ACC: state_d = DRAIN;
      V_ACC: begin
        if (k_q == 3'd7) begin
          state_d = DRAIN;
        end else begin
          k_d         = k_next;
          mem_addr_d  = lat_addr_q + ADDR_W'(k_next);
          mem_we_d    = lat_we_q;
          mem_wdata_d = lat_wdata_q[{k_next, 4'b0000} +: 16];
        end
      end
      DRAIN: begin
        state_d = RESP;
        s_ack_d = ~last_vec_q;
        v_ack_d = last_vec_q;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched transaction fields, registered memory bus and acks.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= 3'd0;
      last_vec_q  <= 1'b1;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      s_ack       <= 1'b0;
      v_ack       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      last_vec_q  <= last_vec_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      mem_addr    <= mem_addr_d;
      mem_we      <= mem_we_d;
      mem_wdata   <= mem_wdata_d;
      s_ack       <= s_ack_d;
      v_ack       <= v_ack_d;
    end
  end

  // Read-data capture: memory answers one cycle after each address.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_rdata <= '0;
      v_rdata <= '0;
    end else if (!lat_we_q) begin
      if (state_q == V_ACC && k_q != 3'd0) begin
        v_rdata[{cap_lane, 4'b0000} +: 16] <= mem_rdata;
      end else if (state_q == DRAIN) begin
        if (last_vec_q) v_rdata[127:112] <= mem_rdata;
        else            s_rdata          <= mem_rdata;
      end
    end
  end

endmodule
